// File: rtl/uart_pkg.sv
// Shared UART constants: FIFO sizing, LSR bit positions and IIR source codes.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_DW         = 8;

  localparam int LSR_THRE_BIT = 5;
  localparam int LSR_TEMT_BIT = 6;

  localparam logic [2:0] IIR_THRE_ID = 3'b001;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with runtime capacity (DEPTH or a single holding register).
// In single-register mode a push into a full register overwrites the held entry.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     cap_1,
  input  logic [DW-1:0]            wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DW-1:0]            head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_write;
  logic          do_overwrite;

  assign full         = level >= (cap_1 ? ONE_L : DEPTH_L);
  assign empty        = (level == '0);
  assign do_pop       = pop & ~empty & ~flush;
  assign do_write     = push & ~flush & (~full | do_pop);
  assign do_overwrite = push & ~flush & full & ~do_pop & cap_1;
  assign head         = empty ? '0 : mem[rd_ptr];

  // Storage array: normal writes go to the tail, an overwrite replaces the head.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end else if (do_overwrite) begin
      mem[rd_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, do_pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit-side sequencer: buffers CPU writes, feeds the head byte to the
// transmitter, tracks the in-flight character and raises the THRE interrupt.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int DW    = UART_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_data,
  input  logic                   fifo_en,
  input  logic                   tx_fifo_rst,
  input  logic                   ier_etbei,
  input  logic                   iir_thre_rd,
  input  logic                   pop,
  input  logic                   sreg_empty,
  output logic                   thre,
  output logic [DW-1:0]          din,
  output logic                   lsr_thre,
  output logic                   lsr_temt,
  output logic                   thre_irq,
  output logic                   wr_drop,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE_L = (AW+1)'(1);

  logic pop_d;
  logic sreg_empty_d;
  logic fifo_en_d;
  logic ier_d;
  logic tx_busy;

  logic fifo_full;
  logic fifo_empty;
  logic pop_q;
  logic sreg_rise;
  logic flush;
  logic accept;
  logic drop_now;
  logic irq_set;
  logic irq_clr;

  // The transmitter holds pop for a whole character, so only its rising edge
  // consumes an entry; a rise with nothing queued is ignored.
  assign pop_q     = pop & ~pop_d & ~fifo_empty;
  assign sreg_rise = sreg_empty & ~sreg_empty_d;

  // Switching between FIFO and holding-register mode discards queued data.
  assign flush = tx_fifo_rst | (fifo_en ^ fifo_en_d);

  // A write lands if there is room, a slot is freed this clock, or it
  // overwrites the single holding register.
  assign accept   = wr_en & ~flush & (~fifo_full | pop_q | ~fifo_en);
  assign drop_now = wr_en & ~flush & fifo_full & ~pop_q;

  assign irq_set = ier_etbei &
                   (((level == ONE_L) & (flush | (pop_q & ~accept))) |
                    (~ier_d & fifo_empty));
  assign irq_clr = accept | iir_thre_rd | ~ier_etbei;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (pop_q),
    .flush   (flush),
    .cap_1   (~fifo_en),
    .wr_data (wr_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level),
    .head    (din)
  );

  assign thre     = fifo_empty;
  assign lsr_thre = thre;
  assign lsr_temt = thre & ~tx_busy;

  // Edge-detect history for pop, sreg_empty, fifo_en and the interrupt enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_d        <= 1'b0;
      sreg_empty_d <= 1'b1;
      fifo_en_d    <= 1'b0;
      ier_d        <= 1'b0;
    end else begin
      pop_d        <= pop;
      sreg_empty_d <= sreg_empty;
      fifo_en_d    <= fifo_en;
      ier_d        <= ier_etbei;
    end
  end

  // Character in flight: starts when a byte is taken, ends when the shifter empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
    end else if (pop_q) begin
      tx_busy <= 1'b1;
    end else if (sreg_rise) begin
      tx_busy <= 1'b0;
    end
  end

  // THRE interrupt request; any clearing cause wins over a same-clock set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thre_irq <= 1'b0;
    end else if (irq_clr) begin
      thre_irq <= 1'b0;
    end else if (irq_set) begin
      thre_irq <= 1'b1;
    end
  end

  // One-clock flag for a write that could not be stored cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop_now;
    end
  end

endmodule
